// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: bounce event codes, the ball
// motion state encoding and the default screen geometry.
package pong_pkg;

  // Default visible area, shared with the bounce/score logic.
  localparam int SCREEN_X_DEFAULT = 640;
  localparam int SCREEN_Y_DEFAULT = 480;

  // Registered bounce event codes produced by the bounce/score logic.
  localparam logic [1:0] BOUNCE_NONE   = 2'd0;
  localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
  localparam logic [1:0] BOUNCE_WALL   = 2'd2;
  localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

  // Ball motion controller states.
  typedef enum logic {
    SERVE = 1'b0,
    PLAY  = 1'b1
  } ball_state_t;

endpackage

// File: rtl/axis_stepper.sv
// Saturating single-axis stepper: moves a 10-bit position by STEP in the
// requested direction and clamps the result into 0..MAX (no wrap-around).
module axis_stepper #(
  parameter int STEP = 2,
  parameter int MAX  = 632
) (
  input  logic [9:0] pos,
  input  logic       dir,
  output logic [9:0] next_pos
);

  // 11-bit arithmetic leaves room to see both overflow past MAX and underflow below 0.
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] MAX_W  = 11'(MAX);

  logic [10:0] w_pos_ext;
  logic [10:0] w_sum;
  logic [10:0] w_diff;

  assign w_pos_ext = {1'b0, pos};
  assign w_sum     = w_pos_ext + STEP_W;
  assign w_diff    = w_pos_ext - STEP_W;

  // Pick the stepped value and clamp it onto the limit it would cross.
  always_comb begin
    next_pos = pos;
    if (dir) begin
      if (w_sum > MAX_W) begin
        next_pos = MAX_W[9:0];
      end else begin
        next_pos = w_sum[9:0];
      end
    end else begin
      if (w_pos_ext < STEP_W) begin
        next_pos = 10'd0;
      end else begin
        next_pos = w_diff[9:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion_fsm.sv
// Ball motion controller: owns ball direction, per-frame stepping, bounce
// de-duplication and the serve hold after a point is scored.
module ball_motion_fsm
  import pong_pkg::*;
#(
  parameter int SCREEN_X    = SCREEN_X_DEFAULT,
  parameter int SCREEN_Y    = SCREEN_Y_DEFAULT,
  parameter int BALL_SIZE   = 8,
  parameter int STEP        = 2,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [1:0] bounce,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [7:0] ball_size_x,
  output logic [7:0] ball_size_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       serving
);

  localparam int X_MAX = SCREEN_X - BALL_SIZE;
  localparam int Y_MAX = SCREEN_Y - BALL_SIZE;
  localparam logic [9:0] CX = 10'(X_MAX / 2);
  localparam logic [9:0] CY = 10'(Y_MAX / 2);
  localparam int CNT_W = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ball_state_t      r_state;
  ball_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_armed;
  logic             w_armed_next;
  logic [9:0]       r_pos_x;
  logic [9:0]       w_pos_x_next;
  logic [9:0]       r_pos_y;
  logic [9:0]       w_pos_y_next;
  logic             r_dir_x;
  logic             w_dir_x_next;
  logic             r_dir_y;
  logic             w_dir_y_next;
  logic             r_serving;
  logic             w_serving_next;

  // Direction used for this tick's step: an armed paddle/wall hit flips
  // the matching axis first, so the ball immediately moves away.
  logic       w_step_dir_x;
  logic       w_step_dir_y;
  logic [9:0] w_step_x;
  logic [9:0] w_step_y;

  assign w_step_dir_x = r_dir_x ^ (r_armed && (bounce == BOUNCE_PADDLE));
  assign w_step_dir_y = r_dir_y ^ (r_armed && (bounce == BOUNCE_WALL));

  axis_stepper #(
    .STEP (STEP),
    .MAX  (X_MAX)
  ) u_step_x (
    .pos      (r_pos_x),
    .dir      (w_step_dir_x),
    .next_pos (w_step_x)
  );

  axis_stepper #(
    .STEP (STEP),
    .MAX  (Y_MAX)
  ) u_step_y (
    .pos      (r_pos_y),
    .dir      (w_step_dir_y),
    .next_pos (w_step_y)
  );

  // State register: reset parks the ball at centre in the serve hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= SERVE;
      r_cnt     <= CNT_INIT;
      r_armed   <= 1'b1;
      r_pos_x   <= CX;
      r_pos_y   <= CY;
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_serving <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_armed   <= w_armed_next;
      r_pos_x   <= w_pos_x_next;
      r_pos_y   <= w_pos_y_next;
      r_dir_x   <= w_dir_x_next;
      r_dir_y   <= w_dir_y_next;
      r_serving <= w_serving_next;
    end
  end

  // Next-state logic: everything holds unless a frame tick arrives.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_armed_next   = r_armed;
    w_pos_x_next   = r_pos_x;
    w_pos_y_next   = r_pos_y;
    w_dir_x_next   = r_dir_x;
    w_dir_y_next   = r_dir_y;
    w_serving_next = r_serving;
    if (frame_tick) begin
      case (r_state)
        SERVE: begin
          // The tick that finds the counter at zero releases the ball
          // without moving it.
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_ONE;
          end else begin
            w_state_next   = PLAY;
            w_serving_next = 1'b0;
          end
        end
        PLAY: begin
          if (bounce == BOUNCE_SCORE) begin
            // Serve toward the player who just scored.
            w_state_next   = SERVE;
            w_cnt_next     = CNT_INIT;
            w_armed_next   = 1'b1;
            w_pos_x_next   = CX;
            w_pos_y_next   = CY;
            w_dir_x_next   = ~r_dir_x;
            w_serving_next = 1'b1;
          end else begin
            // Any contact disarms until a clear frame re-arms, so a
            // contact spanning several frames flips only once.
            w_armed_next = (bounce == BOUNCE_NONE);
            w_dir_x_next = w_step_dir_x;
            w_dir_y_next = w_step_dir_y;
            w_pos_x_next = w_step_x;
            w_pos_y_next = w_step_y;
          end
        end
        default: begin
          w_state_next = SERVE;
        end
      endcase
    end
  end

  assign ball_pos_x  = r_pos_x;
  assign ball_pos_y  = r_pos_y;
  assign dir_x       = r_dir_x;
  assign dir_y       = r_dir_y;
  assign serving     = r_serving;
  assign ball_size_x = 8'(BALL_SIZE);
  assign ball_size_y = 8'(BALL_SIZE);

endmodule

// File: tb/tb_ball_motion_fsm.sv
// Scoreboard bench for ball_motion_fsm: a behavioural model predicts the
// outputs for every driven cycle, expectations are queued on drive and
// popped/compared one clock later.
module tb_ball_motion_fsm;

  // Odd-centred geometry so the ball reaches positions one pixel from a limit.
  localparam int SX    = 642;
  localparam int SY    = 482;
  localparam int BS    = 8;
  localparam int ST    = 2;
  localparam int SD    = 4;
  localparam int XMAX  = SX - BS;
  localparam int YMAX  = SY - BS;
  localparam int CX    = XMAX / 2;
  localparam int CY    = YMAX / 2;

  logic       clock;
  logic       reset_n;
  logic       frame_tick;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [7:0] ball_size_x;
  logic [7:0] ball_size_y;
  logic       dir_x;
  logic       dir_y;
  logic       serving;

  ball_motion_fsm #(
    .SCREEN_X    (SX),
    .SCREEN_Y    (SY),
    .BALL_SIZE   (BS),
    .STEP        (ST),
    .SERVE_DELAY (SD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .bounce      (bounce),
    .ball_pos_x  (ball_pos_x),
    .ball_pos_y  (ball_pos_y),
    .ball_size_x (ball_size_x),
    .ball_size_y (ball_size_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .serving     (serving)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int srv;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  // Behavioural model state.
  int m_x, m_y, m_dx, m_dy, m_srv, m_cnt, m_armed;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_srv = 1; m_cnt = SD; m_armed = 1;
  endtask

  function automatic int clamp_step(input int p, input int d, input int lim);
    int n;
    n = d ? p + ST : p - ST;
    if (n < 0) n = 0;
    if (n > lim) n = lim;
    return n;
  endfunction

  task automatic model_tick(input int b);
    if (m_srv != 0) begin
      if (m_cnt != 0) m_cnt--;
      else m_srv = 0;
    end else if (b == 3) begin
      m_srv = 1; m_x = CX; m_y = CY; m_cnt = SD;
      m_dx = (m_dx == 0) ? 1 : 0;
      m_armed = 1;
    end else begin
      if (b == 1 && m_armed == 1) begin
        m_dx = (m_dx == 0) ? 1 : 0;
        m_armed = 0;
      end else if (b == 2 && m_armed == 1) begin
        m_dy = (m_dy == 0) ? 1 : 0;
        m_armed = 0;
      end else if (b == 0) begin
        m_armed = 1;
      end
      m_x = clamp_step(m_x, m_dx, XMAX);
      m_y = clamp_step(m_y, m_dy, YMAX);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy; e.srv = m_srv;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check_val({tag, ".depth"}, sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_txn++;
      $display("txn %0d %s: pos (%0d,%0d) dir (%0d,%0d) serving %0d size %0d/%0d",
               n_txn, tag, ball_pos_x, ball_pos_y, dir_x, dir_y, serving,
               ball_size_x, ball_size_y);
      check_val({tag, ".x"}, int'(ball_pos_x), e.x);
      check_val({tag, ".y"}, int'(ball_pos_y), e.y);
      check_val({tag, ".dir_x"}, int'(dir_x), e.dx);
      check_val({tag, ".dir_y"}, int'(dir_y), e.dy);
      check_val({tag, ".serving"}, int'(serving), e.srv);
      check_val({tag, ".size_x"}, int'(ball_size_x), BS);
      check_val({tag, ".size_y"}, int'(ball_size_y), BS);
    end
  endtask

  // One cycle with frame_tick low; bounce is noise that must be ignored.
  task automatic idle_cycle(input int b);
    @(negedge clock);
    frame_tick = 1'b0;
    bounce     = 2'(b);
    push_expect();
    @(posedge clock);
    #1;
    compare_out("idle");
  endtask

  task automatic tick(input int b, input string tag);
    @(negedge clock);
    frame_tick = 1'b1;
    bounce     = 2'(b);
    model_tick(b);
    push_expect();
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    compare_out(tag);
  endtask

  task automatic reset_cycle(input logic ft, input int b, input string tag);
    @(negedge clock);
    reset_n    = 1'b0;
    frame_tick = ft;
    bounce     = 2'(b);
    model_reset();
    push_expect();
    @(posedge clock);
    #1;
    compare_out(tag);
    reset_n    = 1'b1;
    frame_tick = 1'b0;
    bounce     = 2'd0;
  endtask

  // Steer the ball into the chosen corner and hold it against both limits.
  task automatic walk(input int tx, input int ty, input int extra);
    int reached;
    int held;
    int b;
    reached = 0;
    held    = 0;
    for (int i = 0; i < 600 && held < extra; i++) begin
      if (m_dx != tx && m_armed == 1) b = 1;
      else if (m_dy != ty && m_armed == 1) b = 2;
      else b = 0;
      tick(b, "walk");
      if (m_x == (tx ? XMAX : 0) && m_y == (ty ? YMAX : 0)) begin
        reached = 1;
        held++;
      end
    end
    check_val("walk.reached", reached, 1);
  endtask

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    bounce     = 2'd0;
    model_reset();

    // Reset state, including ignored tick/bounce while held.
    reset_cycle(1'b0, 0, "reset");
    reset_cycle(1'b1, 2, "reset_tick");
    for (int i = 0; i < 10; i++) idle_cycle(i % 4);

    // Serve hold: serving drops on tick SD+1 without motion, then steps.
    for (int i = 0; i < SD + 1; i++) tick(0, "serve");
    tick(0, "first_step");

    // Persistent paddle contact flips once; a clear frame re-arms.
    tick(1, "paddle1");
    tick(1, "paddle2");
    tick(1, "paddle3");
    tick(0, "rearm");
    tick(1, "paddle_again");
    idle_cycle(1);
    tick(2, "wall1");
    tick(2, "wall2");
    tick(0, "wall_rearm");

    // Saturation at the limits from one pixel away, then the opposite corner.
    walk(0, 1, 3);
    walk(1, 0, 3);
    walk(0, 0, 2);

    // Point scored while moving left/up: recentre, serve toward scorer.
    tick(3, "score");
    idle_cycle(3);
    for (int i = 0; i < SD + 1; i++) tick(3, "serve2");
    tick(0, "serve2_step");

    // Random mix of events with idle gaps.
    for (int i = 0; i < 150; i++) begin
      int r;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 3));
      r = $urandom_range(0, 15);
      tick((r < 6) ? 0 : (r < 10) ? 1 : (r < 14) ? 2 : 3, "rand");
    end

    // Reset mid-play coincident with a tick and a paddle hit.
    while (m_srv != 0) tick(0, "to_play");
    tick(0, "play");
    reset_cycle(1'b1, 1, "reset_mid_play");
    idle_cycle(0);
    tick(1, "after_reset");

    check_val("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
